insn_loader: RTL and testbench
==============================

Name: insn_loader

Overview:
Host-facing loader that fills the instruction memory's parallel load port. It accepts instructions one word at a time over a valid/ready stream and collects them in a shadow buffer. When the programmed count has arrived, it drives the full buffer onto the wide insn_data bus with a single-cycle init_insn_mem strobe. It sits between the host/DMA interface and the core's instruction memory.

Parameters:
INSN_COUNT, 16 (default taken from shared constants), number of instruction slots in the target memory
INSN_SIZE, 16 (default taken from shared constants), instruction width in bits
INSN_PTR_SIZE, 4 (default taken from shared constants), slot index width; INSN_COUNT == 2**INSN_PTR_SIZE

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a load session; sampled only in IDLE
load_len  in  INSN_PTR_SIZE+1  number of instructions to receive, legal 1..INSN_COUNT; sampled with start
abort  in  1  cancel the session in progress; no commit occurs
in_valid  in  1  in_insn carries a valid word
in_ready  out  1  loader accepts a word this cycle
in_insn  in  INSN_SIZE  instruction word, in slot order 0,1,2,...
busy  out  1  high whenever state != IDLE
init_insn_mem  out  1  one-cycle commit strobe to the instruction memory
insn_data  out  INSN_COUNT*INSN_SIZE  shadow buffer; slot i occupies bits [(i+1)*INSN_SIZE-1 : i*INSN_SIZE]
done  out  1  one-cycle pulse after a successful commit
err  out  1  one-cycle pulse on an illegal load_len

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; wr_ptr = 0, len_q = 0; in_ready, busy, init_insn_mem, done and err all 0; every shadow slot = INSN_NOP (all zeros).
- States: IDLE, LOAD, COMMIT, DONE.
- IDLE, start=1 and load_len in 1..INSN_COUNT:
  - latch len_q = load_len; wr_ptr = 0;
  - reset every shadow slot to INSN_NOP in the same edge;
  - next state = LOAD.
- IDLE, start=1 and load_len = 0 or load_len > INSN_COUNT: err = 1 for one cycle; stay in IDLE; buffer is untouched.
- IDLE, start=0: hold state. in_ready = 0.
- LOAD:
  - in_ready = 1 combinationally, and only in this state.
  - A transfer occurs when in_valid & in_ready. On a transfer, slot[wr_ptr] = in_insn and wr_ptr increments.
  - If the transfer is word number len_q, next state = COMMIT.
  - wr_ptr is INSN_PTR_SIZE+1 bits wide, so the count reaches INSN_COUNT without wrapping. The slot index is the low bits only.
- COMMIT: init_insn_mem = 1 for exactly one cycle; insn_data is stable; next state = DONE.
- DONE: done = 1 for one cycle; next state = IDLE.
- Latency: last word accepted at edge N -> init_insn_mem high in cycle N+1 -> done high in cycle N+2 -> in IDLE and able to take start at edge N+3.
- Slots at index >= len_q stay INSN_NOP at commit.
- insn_data holds its value after the commit until the next legal start. The memory only samples it while init_insn_mem is high.
- abort in LOAD: return to IDLE at the next edge. No init_insn_mem and no done. The buffer keeps its partial contents; that is harmless because no commit occurs.
- abort in COMMIT or DONE: ignored; the commit completes.
- abort and a transfer in the same LOAD cycle: abort wins and the word is dropped.
- start outside IDLE: ignored, with no err.
- Reset asserted mid-LOAD or mid-COMMIT: immediate return to reset values. An init_insn_mem pulse in progress is truncated.

Decomposition:
- Shared constants header gets:
  - INSN_NOP (all-zero word);
  - the loader state encodings LDR_IDLE=2'd0, LDR_LOAD=2'd1, LDR_COMMIT=2'd2, LDR_DONE=2'd3;
  - the existing INSN_COUNT, INSN_SIZE and INSN_PTR_SIZE.
- Sub-module insn_shadow_buf: the INSN_COUNT x INSN_SIZE register array with clear_all, wr_en, wr_idx and wr_data, flattened to insn_data. The FSM and handshake stay in insn_loader.

Test Plan:
- Full load: start with load_len=16; send words 16'h1000+i with in_valid held high -> in_ready high 16 cycles; init_insn_mem pulses once the cycle after word 15; insn_data slot i = 16'h1000+i; done the following cycle.
- Partial load with bubbles: load_len=3; send A1,B2,C3 with in_valid low between words -> commit has slots 0..2 = A1,B2,C3 and slots 3..15 = 0; exactly one init pulse.
- Illegal length: start with load_len=0, then again with load_len=17 -> err pulses each time; busy stays 0; no init pulse; buffer unchanged.
- Abort: load_len=8; abort after 4 words, asserted together with a 5th valid word -> back in IDLE next cycle; no init pulse and no done. A following full load commits correctly.
- Asynchronous reset mid-LOAD: drop reset between clock edges after 2 words -> all outputs 0 immediately and insn_data all zeros. After release, start works normally.
- Back-to-back sessions: assert start in the cycle after done -> the new session begins; the previous contents are cleared to NOP at that start edge.

Source files
------------

// File: rtl/insn_loader_pkg.sv
// Shared constants for the instruction loader: memory geometry, NOP word and loader states.
package insn_loader_pkg;

    localparam int unsigned INSN_COUNT    = 16;
    localparam int unsigned INSN_SIZE     = 16;
    localparam int unsigned INSN_PTR_SIZE = 4;

    localparam logic [INSN_SIZE-1:0] INSN_NOP = '0;

    typedef enum logic [1:0] {
        LDR_IDLE   = 2'd0,
        LDR_LOAD   = 2'd1,
        LDR_COMMIT = 2'd2,
        LDR_DONE   = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/insn_loader_if.sv
// Host-side instruction word stream (valid/ready) feeding the loader.
interface insn_loader_if #(
    parameter int unsigned INSN_SIZE = insn_loader_pkg::INSN_SIZE
);

    logic                 in_valid;
    logic                 in_ready;
    logic [INSN_SIZE-1:0] in_insn;

    modport master (output in_valid, output in_insn, input in_ready);
    modport slave  (input in_valid, input in_insn, output in_ready);

endinterface

// File: rtl/insn_loader_shadow_buf.sv
// Shadow register array for the instruction memory load port, flattened onto insn_data.
module insn_shadow_buf
    import insn_loader_pkg::*;
#(
    parameter int unsigned INSN_COUNT    = insn_loader_pkg::INSN_COUNT,
    parameter int unsigned INSN_SIZE     = insn_loader_pkg::INSN_SIZE,
    parameter int unsigned INSN_PTR_SIZE = insn_loader_pkg::INSN_PTR_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_all,
    input  logic                            wr_en,
    input  logic [INSN_PTR_SIZE-1:0]        wr_idx,
    input  logic [INSN_SIZE-1:0]            wr_data,
    output logic [INSN_COUNT*INSN_SIZE-1:0] insn_data
);

    logic [INSN_SIZE-1:0] slot_q [INSN_COUNT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < INSN_COUNT; i++) begin
                slot_q[i] <= INSN_SIZE'(INSN_NOP);
            end
        end else if (clear_all) begin
            for (int unsigned i = 0; i < INSN_COUNT; i++) begin
                slot_q[i] <= INSN_SIZE'(INSN_NOP);
            end
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        insn_data = '0;
        for (int unsigned i = 0; i < INSN_COUNT; i++) begin
            insn_data[i*INSN_SIZE +: INSN_SIZE] = slot_q[i];
        end
    end

endmodule

// File: rtl/insn_loader.sv
// Collects instruction words from the host stream into a shadow buffer and commits
// the whole buffer to instruction memory with a single init_insn_mem strobe.
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int unsigned INSN_COUNT    = insn_loader_pkg::INSN_COUNT,
    parameter int unsigned INSN_SIZE     = insn_loader_pkg::INSN_SIZE,
    parameter int unsigned INSN_PTR_SIZE = insn_loader_pkg::INSN_PTR_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [INSN_PTR_SIZE:0]          load_len,
    input  logic                            abort,
    insn_loader_if.slave                    in_if,
    output logic                            busy,
    output logic                            init_insn_mem,
    output logic [INSN_COUNT*INSN_SIZE-1:0] insn_data,
    output logic                            done,
    output logic                            err
);

    localparam logic [INSN_PTR_SIZE:0] LEN_MAX = (INSN_PTR_SIZE+1)'(INSN_COUNT);
    localparam logic [INSN_PTR_SIZE:0] PTR_ONE = (INSN_PTR_SIZE+1)'(1);

    ldr_state_t             state_q, state_d;
    logic [INSN_PTR_SIZE:0] wr_ptr_q;
    logic [INSN_PTR_SIZE:0] len_q;
    logic                   err_q;

    logic len_ok;
    logic start_ok;
    logic xfer;
    logic last_xfer;

    assign len_ok   = (load_len != '0) && (load_len <= LEN_MAX);
    assign start_ok = (state_q == LDR_IDLE) && start && len_ok;
    // abort takes priority: a word offered in the abort cycle is dropped
    assign xfer      = in_if.in_valid && in_if.in_ready && !abort;
    assign last_xfer = xfer && ((wr_ptr_q + PTR_ONE) == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_IDLE:   if (start_ok) state_d = LDR_LOAD;
            LDR_LOAD: begin
                if (abort)          state_d = LDR_IDLE;
                else if (last_xfer) state_d = LDR_COMMIT;
            end
            LDR_COMMIT: state_d = LDR_DONE;
            LDR_DONE:   state_d = LDR_IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = (state_q == LDR_LOAD);
        busy           = (state_q != LDR_IDLE);
        init_insn_mem  = (state_q == LDR_COMMIT);
        done           = (state_q == LDR_DONE);
        err            = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state_q == LDR_IDLE) && start && !len_ok;
            if (start_ok) begin
                len_q    <= load_len;
                wr_ptr_q <= '0;
            end else if (xfer) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
        end
    end

    insn_shadow_buf #(
        .INSN_COUNT    (INSN_COUNT),
        .INSN_SIZE     (INSN_SIZE),
        .INSN_PTR_SIZE (INSN_PTR_SIZE)
    ) u_shadow_buf (
        .clk       (clk),
        .reset     (reset),
        .clear_all (start_ok),
        .wr_en     (xfer),
        .wr_idx    (wr_ptr_q[INSN_PTR_SIZE-1:0]),
        .wr_data   (in_if.in_insn),
        .insn_data (insn_data)
    );

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: directed session table, async reset case, random sessions.
module tb_insn_loader;
    import insn_loader_pkg::*;

    localparam int unsigned W = INSN_COUNT * INSN_SIZE;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   abort;
    logic [INSN_PTR_SIZE:0] load_len;
    logic                   busy;
    logic                   init_insn_mem;
    logic                   done;
    logic                   err;
    logic [W-1:0]           insn_data;

    int vectors     = 0;
    int miscompares = 0;

    // expected contents of the shadow buffer as seen on insn_data
    logic [W-1:0] model;

    insn_loader_if #(.INSN_SIZE(INSN_SIZE)) in_bus ();

    insn_loader #(
        .INSN_COUNT    (INSN_COUNT),
        .INSN_SIZE     (INSN_SIZE),
        .INSN_PTR_SIZE (INSN_PTR_SIZE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_len      (load_len),
        .abort         (abort),
        .in_if         (in_bus),
        .busy          (busy),
        .init_insn_mem (init_insn_mem),
        .insn_data     (insn_data),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          abort_at;
        logic [15:0] base;
        logic [15:0] step;
        int          gap;
        bit          abort_commit;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one session starting in an IDLE cycle; ends one cycle after DONE (back in IDLE).
    task automatic run_session(input int len, input int abort_at, input logic [15:0] base,
                               input logic [15:0] step, input int gap, input bit abort_commit,
                               input bit rnd, input bit exp_err);
        int          sent;
        int          cyc;
        bit          v;
        bit          ab;
        logic [15:0] w;
        start    = 1'b1;
        load_len = (INSN_PTR_SIZE+1)'(len);
        @(negedge clk);
        chk("idle_ready", in_bus.in_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data", insn_data, model);
        tick();
        start = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_init", init_insn_mem, 0);
            chk("err_data", insn_data, model);
            tick();
            @(negedge clk);
            chk("err_single", err, 0);
            chk("err_busy2", busy, 0);
            tick();
            return;
        end
        model = '0;
        sent  = 0;
        cyc   = 0;
        while (sent < len && cyc < 400) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 0);
            else               v = ($urandom_range(99) >= 30);
            w  = rnd ? 16'($urandom) : 16'(int'(base) + int'(step) * sent);
            ab = (sent == abort_at) && v;
            in_bus.in_valid = v;
            in_bus.in_insn  = w;
            abort           = ab;
            start           = rnd ? 1'($urandom) : 1'b0;
            load_len        = (INSN_PTR_SIZE+1)'($urandom_range(0, 20));
            @(negedge clk);
            chk("load_ready", in_bus.in_ready, 1);
            chk("load_busy", busy, 1);
            chk("load_init", init_insn_mem, 0);
            chk("load_done", done, 0);
            chk("load_err", err, 0);
            chk("load_data", insn_data, model);
            tick();
            cyc++;
            in_bus.in_valid = 1'b0;
            abort           = 1'b0;
            start           = 1'b0;
            if (ab) begin
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_ready", in_bus.in_ready, 0);
                chk("abort_init", init_insn_mem, 0);
                chk("abort_done", done, 0);
                chk("abort_data", insn_data, model);
                tick();
                return;
            end
            if (v) begin
                model[sent*INSN_SIZE +: INSN_SIZE] = w;
                sent++;
            end
        end
        if (sent < len) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got %0d words expected %0d", sent, len);
            return;
        end
        abort = abort_commit;
        @(negedge clk);
        chk("commit_init", init_insn_mem, 1);
        chk("commit_data", insn_data, model);
        chk("commit_ready", in_bus.in_ready, 0);
        chk("commit_busy", busy, 1);
        chk("commit_done", done, 0);
        chk("commit_err", err, 0);
        tick();
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_init", init_insn_mem, 0);
        chk("done_busy", busy, 1);
        chk("done_data", insn_data, model);
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int rlen;
        reset           = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        load_len        = '0;
        in_bus.in_valid = 1'b0;
        in_bus.in_insn  = '0;
        model           = '0;

        #12;
        chk("rst_ready", in_bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init", init_insn_mem, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", insn_data, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        tbl[0] = '{16, -1, 16'h1000, 16'h0001, 0, 1'b0, 1'b0};
        tbl[1] = '{3,  -1, 16'h00A1, 16'h0011, 1, 1'b0, 1'b0};
        tbl[2] = '{0,  -1, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        tbl[3] = '{17, -1, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        tbl[4] = '{8,   4, 16'h2000, 16'h0001, 0, 1'b0, 1'b0};
        tbl[5] = '{16, -1, 16'h3000, 16'h0101, 0, 1'b0, 1'b0};
        tbl[6] = '{1,  -1, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0};
        tbl[7] = '{16, -1, 16'h5A00, 16'h0003, 1, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            run_session(tbl[i].len, tbl[i].abort_at, tbl[i].base, tbl[i].step,
                        tbl[i].gap, tbl[i].abort_commit, 1'b0, tbl[i].exp_err);
        end

        // asynchronous reset in the middle of a load
        start    = 1'b1;
        load_len = (INSN_PTR_SIZE+1)'(8);
        tick();
        start = 1'b0;
        model = '0;
        for (int i = 0; i < 2; i++) begin
            in_bus.in_valid = 1'b1;
            in_bus.in_insn  = 16'(16'hBEE0 + i);
            tick();
            model[i*INSN_SIZE +: INSN_SIZE] = 16'(16'hBEE0 + i);
        end
        in_bus.in_valid = 1'b0;
        @(negedge clk);
        chk("prerst_data", insn_data, model);
        chk("prerst_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ready", in_bus.in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_init", init_insn_mem, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_data", insn_data, '0);
        model = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        run_session(16, -1, 16'h4000, 16'h0001, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rlen = $urandom_range(0, 18);
            run_session(rlen,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, rlen) : -1,
                        16'h0000, 16'h0000, 2, 1'($urandom), 1'b1,
                        (rlen == 0) || (rlen > INSN_COUNT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
